logic_sweep_ctrl: RTL and testbench
===================================

LOGIC_SWEEP_CTRL -- requirements
Module: logic_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: number of clock cycles each input vector is held before d is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 start  input  1  request a full 8-vector sweep; sampled only in IDLE.
REQ-005 expected  input  8  golden truth table; bit i is the expected d for {a,b,c}=i; latched when start is accepted.
REQ-006 d  input  1  output of the 3-input logic block under control; treated as synchronous to clk.
REQ-007 a, b, c  output  1 each  registered drive to the logic block; {a,b,c} equals the current vector index.
REQ-008 busy  output  1  high in SETTLE and SAMPLE.
REQ-009 done  output  1  one-cycle pulse when a sweep completes.
REQ-010 pass  output  1  high when the captured table equals the latched expected value; valid from done until the next accepted start.
REQ-011 table_out  output  8  captured truth table; bit i is d sampled for vector i.
REQ-012 mismatch_cnt  output  4  number of bits where table_out differs from the latched expected value (0..8).
REQ-013 first_fail_idx  output  3  lowest vector index that mismatched; 0 when there are no mismatches.

Function
REQ-014 The state machine SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 In IDLE, start=1 at an edge SHALL cause these updates at that edge:
- vector index to 0, driving {a,b,c}=000;
- expected latched;
- table_out, mismatch_cnt, first_fail_idx and pass cleared;
- settle counter to 0;
- next state SETTLE.
REQ-016 In SETTLE, the controller SHALL stay for exactly SETTLE_CYCLES cycles, then move to SAMPLE.
REQ-017 In SAMPLE, at one edge the controller SHALL:
- write d into table_out[index];
- if d differs from the expected bit, increment mismatch_cnt, and update first_fail_idx if this is the first mismatch.
REQ-018 At that same SAMPLE edge:
- if index is below 7, the index SHALL increment, {a,b,c} SHALL update and the next state SHALL be SETTLE with the settle counter at 0;
- if index is 7, the next state SHALL be DONE.
REQ-019 Vector i SHALL be captured at edge (i+1)*(SETTLE_CYCLES+1) after the start-accepting edge; with the default, the last capture is at edge 24.
REQ-020 In DONE, done SHALL be 1 and pass SHALL equal (table_out==expected_latched) for one cycle; the next state SHALL be IDLE.
REQ-021 start SHALL be ignored in SETTLE, SAMPLE and DONE; there is no queuing.
REQ-022 table_out, mismatch_cnt, first_fail_idx and pass SHALL hold their values in IDLE until the next accepted start.
REQ-023 Vector index SHALL never wrap; no sample occurs after index 7.
REQ-024 Changes to the expected input after start is accepted SHALL have no effect on the sweep.

Reset
REQ-025 rst_n=0 SHALL immediately force:
- state IDLE;
- a=b=c=0, busy=0, done=0, pass=0;
- table_out=0, mismatch_cnt=0, first_fail_idx=0;
- settle counter and latched expected value to 0.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; the first rising edge with rst_n=1 SHALL be treated as IDLE.

Structure
REQ-027 State encodings (2-bit), NUM_VECTORS=8 and the default SETTLE_CYCLES SHALL live in a shared constants package, logic_sweep_pkg, used by the RTL and the bench.
REQ-028 The settle delay SHALL be a sub-module, settle_timer (load/count/expire), instantiated once.

Verification
REQ-029 Model d=a, SETTLE_CYCLES=2, expected=8'hF0, start pulsed once -> busy for 24 cycles, done pulse at cycle 25, table_out=8'hF0, pass=1, mismatch_cnt=0, first_fail_idx=0.
REQ-030 Model d=a, expected=8'hF1 -> pass=0, mismatch_cnt=1, first_fail_idx=0, table_out=8'hF0.
REQ-031 Model d=a|b|c, expected=8'h00 -> table_out=8'hFE, mismatch_cnt=7, first_fail_idx=1, pass=0.
REQ-032 start held high through the whole sweep and DONE -> exactly one sweep and one done pulse, then a new sweep begins from IDLE.
REQ-033 rst_n pulled low while {a,b,c}=011 -> all outputs 0 immediately, no done pulse; a following start yields a complete, correct sweep.
REQ-034 SETTLE_CYCLES=1, d=~c, expected=8'h55 -> last capture at edge 16, table_out=8'h55, pass=1.

Source files
------------

// File: rtl/logic_sweep_pkg.sv
// Shared constants for the logic sweep controller: FSM encoding, vector count, default settle time.
package logic_sweep_pkg;

    localparam int NUM_VECTORS           = 8;
    localparam int IDX_W                 = 3;
    localparam int CNT_W                 = 4;
    localparam int SETTLE_CYCLES_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/logic_sweep_ctrl_if.sv
// Request/result bundle between a sweep requester (master) and the sweep controller (slave).
interface logic_sweep_ctrl_if;

    logic       start;
    logic [7:0] expected;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] table_out;
    logic [3:0] mismatch_cnt;
    logic [2:0] first_fail_idx;

    modport master (
        output start, expected,
        input  busy, done, pass, table_out, mismatch_cnt, first_fail_idx
    );

    modport slave (
        input  start, expected,
        output busy, done, pass, table_out, mismatch_cnt, first_fail_idx
    );

endinterface

// File: rtl/logic_sweep_ctrl_settle_timer.sv
// Purpose: counts settle cycles for one input vector; load clears, count advances.
// Latency: expire is combinational from the count, high in the CYCLES-th counting cycle.
// Backpressure: none; the controller decides when to count.
module settle_timer
    import logic_sweep_pkg::*;
#(
    parameter int unsigned CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (count) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire = (cnt_q == CNT_W'(CYCLES - 1));

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Purpose: drives all 8 input vectors into a 3-input logic block, captures d, compares to a golden table.
// Latency: vector i captured (i+1)*(SETTLE_CYCLES+1) edges after start; done pulses one cycle later.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped, not queued.
module logic_sweep_ctrl
    import logic_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_sweep_ctrl_if.slave  ctrl,
    output logic               a,
    output logic               b,
    output logic               c,
    input  logic               d
);

    sweep_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       exp_q;
    logic [7:0]       table_q;
    logic [3:0]       mm_q;
    logic [3:0]       mm_nxt;
    logic [2:0]       ffi_q;
    logic             pass_q;

    logic accept;
    logic sample;
    logic last_vec;
    logic miss;
    logic tmr_load;
    logic tmr_count;
    logic tmr_expire;

    settle_timer #(.CYCLES(SETTLE_CYCLES)) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .count  (tmr_count),
        .expire (tmr_expire)
    );

    assign last_vec = (idx_q == IDX_W'(NUM_VECTORS - 1));
    assign miss     = d ^ exp_q[idx_q];
    assign mm_nxt   = mm_q + {3'b000, miss};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        sample    = 1'b0;
        tmr_load  = 1'b0;
        tmr_count = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl.start) begin
                    accept   = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                tmr_count = 1'b1;
                if (tmr_expire) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                sample = 1'b1;
                if (last_vec) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Results hold through IDLE so software can read them long after done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            exp_q   <= '0;
            table_q <= '0;
            mm_q    <= '0;
            ffi_q   <= '0;
            pass_q  <= 1'b0;
        end else if (accept) begin
            idx_q   <= '0;
            exp_q   <= ctrl.expected;
            table_q <= '0;
            mm_q    <= '0;
            ffi_q   <= '0;
            pass_q  <= 1'b0;
        end else if (sample) begin
            table_q[idx_q] <= d;
            mm_q           <= mm_nxt;
            if (miss && (mm_q == 4'd0)) begin
                ffi_q <= idx_q;
            end
            if (last_vec) begin
                // Zero mismatches over all eight vectors is exactly table == expected.
                pass_q <= (mm_nxt == 4'd0);
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign {a, b, c}           = idx_q;
    assign ctrl.busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign ctrl.done           = (state_q == ST_DONE);
    assign ctrl.pass           = pass_q;
    assign ctrl.table_out      = table_q;
    assign ctrl.mismatch_cnt   = mm_q;
    assign ctrl.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Bench for logic_sweep_ctrl: table of logic-block models and golden tables plus corner-case sequences.
module tb_logic_sweep_ctrl;
    import logic_sweep_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic a1, b1, c1, d1;
    logic a2, b2, c2, d2;
    int   fn;
    int   n_cmp = 0;
    int   n_err = 0;

    logic_sweep_ctrl_if if1 ();
    logic_sweep_ctrl_if if2 ();

    // Logic block under control for the default-settle instance.
    always_comb begin
        case (fn)
            0:       d1 = a1;
            1:       d1 = a1 | b1 | c1;
            2:       d1 = b1 ^ c1;
            3:       d1 = a1 & b1 & c1;
            default: d1 = 1'b0;
        endcase
    end
    assign d2 = ~c2;

    logic_sweep_ctrl #(.SETTLE_CYCLES(SETTLE_CYCLES_DEFAULT)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .ctrl (if1),
        .a (a1), .b (b1), .c (c1), .d (d1)
    );

    logic_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut2 (
        .clk (clk), .rst_n (rst_n), .ctrl (if2),
        .a (a2), .b (b2), .c (c2), .d (d2)
    );

    typedef struct {
        int         fn;
        logic [7:0] exp_in;
        logic [7:0] tbl;
        logic [3:0] mm;
        logic [2:0] ffi;
        logic       ps;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Pulses start on dut1, scrambles expected afterwards, waits for done at a negedge.
    task automatic sweep1(input logic [7:0] expv, output int busy_cycles,
                          output bit got_done, output int abc_bad);
        int k;
        @(negedge clk);
        if1.expected = expv;
        if1.start    = 1'b1;
        @(negedge clk);
        if1.start    = 1'b0;
        if1.expected = ~expv;
        busy_cycles  = 0;
        got_done     = 1'b0;
        abc_bad      = 0;
        k            = 1;
        while (!got_done && k < 200) begin
            if (if1.done) begin
                got_done = 1'b1;
            end else begin
                if (if1.busy) busy_cycles++;
                if ({a1, b1, c1} != 3'((k - 1) / (SETTLE_CYCLES_DEFAULT + 1))) abc_bad++;
                k++;
                @(negedge clk);
            end
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, ".table"}, if1.table_out, v.tbl);
        check({tag, ".mm"},    if1.mismatch_cnt, v.mm);
        check({tag, ".ffi"},   if1.first_fail_idx, v.ffi);
        check({tag, ".pass"},  if1.pass, v.ps);
    endtask

    initial begin
        int   bc;
        bit   gd;
        int   bad;
        int   dn;
        int   busy_pre;
        bit   restarted;
        vec_t v;

        vecs[0] = '{0, 8'hF0, 8'hF0, 4'd0, 3'd0, 1'b1};
        vecs[1] = '{0, 8'hF1, 8'hF0, 4'd1, 3'd0, 1'b0};
        vecs[2] = '{1, 8'h00, 8'hFE, 4'd7, 3'd1, 1'b0};
        vecs[3] = '{2, 8'h66, 8'h66, 4'd0, 3'd0, 1'b1};
        vecs[4] = '{3, 8'h00, 8'h80, 4'd1, 3'd7, 1'b0};
        vecs[5] = '{4, 8'hFF, 8'h00, 4'd8, 3'd0, 1'b0};

        fn           = 0;
        rst_n        = 1'b0;
        if1.start    = 1'b0;
        if1.expected = 8'h00;
        if2.start    = 1'b0;
        if2.expected = 8'h00;
        #3;
        check("reset.outputs",
              {a1, b1, c1, if1.busy, if1.done, if1.pass, if1.table_out, if1.mismatch_cnt, if1.first_fail_idx},
              '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            v  = vecs[i];
            fn = v.fn;
            sweep1(v.exp_in, bc, gd, bad);
            check($sformatf("v%0d.done_seen", i), 32'(gd), 32'd1);
            check($sformatf("v%0d.busy_cycles", i), bc, 8 * (SETTLE_CYCLES_DEFAULT + 1));
            check($sformatf("v%0d.abc_seq", i), bad, 0);
            check_result($sformatf("v%0d", i), v);
            @(negedge clk);
            check($sformatf("v%0d.done_one_cycle", i), {if1.done, if1.busy}, 2'b00);
            check_result($sformatf("v%0d.hold", i), v);
        end

        // start held high through the sweep: one done, then a fresh sweep from IDLE.
        fn = 0;
        @(negedge clk);
        if1.expected = 8'hF0;
        if1.start    = 1'b1;
        dn = 0; busy_pre = 0; restarted = 1'b0;
        for (int k = 0; k < 200 && !restarted; k++) begin
            @(negedge clk);
            if (if1.done) dn++;
            else if (if1.busy && dn == 0) busy_pre++;
            else if (if1.busy && dn > 0) restarted = 1'b1;
        end
        if1.start = 1'b0;
        check("hold.done_count", dn, 1);
        check("hold.restarted", 32'(restarted), 32'd1);
        check("hold.busy_cycles", busy_pre, 24);
        gd = 1'b0;
        for (int k = 0; k < 200 && !gd; k++) begin
            @(negedge clk);
            if (if1.done) gd = 1'b1;
        end
        check("hold.second_done", 32'(gd), 32'd1);
        check_result("hold", vecs[0]);

        // Reset in the middle of a sweep while {a,b,c}=011.
        fn = 0;
        @(negedge clk);
        if1.expected = 8'hF0;
        if1.start    = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        gd = 1'b0;
        for (int k = 0; k < 200 && !gd; k++) begin
            if ({a1, b1, c1} == 3'b011) gd = 1'b1;
            else @(negedge clk);
        end
        check("rst.reached_011", 32'(gd), 32'd1);
        check("rst.partial_table", if1.table_out, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        check("rst.outputs",
              {a1, b1, c1, if1.busy, if1.done, if1.pass, if1.table_out, if1.mismatch_cnt, if1.first_fail_idx},
              '0);
        dn = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (if1.done) dn++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if1.done || if1.busy) dn++;
        end
        check("rst.no_done", dn, 0);
        sweep1(8'hF0, bc, gd, bad);
        check("rst.resweep_done", 32'(gd), 32'd1);
        check("rst.resweep_busy", bc, 24);
        check_result("rst.resweep", vecs[0]);

        // Single-cycle settle instance: d = ~c, last capture 16 edges after start.
        @(negedge clk);
        if2.expected = 8'h55;
        if2.start    = 1'b1;
        @(negedge clk);
        if2.start    = 1'b0;
        if2.expected = 8'h00;
        bc = 0; gd = 1'b0;
        for (int k = 0; k < 200 && !gd; k++) begin
            if (if2.done) gd = 1'b1;
            else begin
                if (if2.busy) bc++;
                @(negedge clk);
            end
        end
        check("s1.done_seen", 32'(gd), 32'd1);
        check("s1.busy_cycles", bc, 16);
        check("s1.table", if2.table_out, 8'h55);
        check("s1.pass", if2.pass, 1'b1);
        check("s1.mm", if2.mismatch_cnt, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
